mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the FPG8 processor bus: serves the read and write strobes issued by the control unit, which are generated together with `MAR_in`/`MDR_in`, from an internal single-port word RAM. It sits between the datapath's address/data buses and the block RAM. It also arbitrates a program-loader write port against CPU traffic, and reports protocol faults (conflicting strobes, out-of-range address, protected-region writes) to the rest of the design.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 16-bit words.
- `PROT_LIMIT`, 16'h0040: addresses below this value are the protected region (used only with the configuration macro).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rd_en`, in, 1: CPU read strobe (`RAM_enable_read`).
- `wr_en`, in, 1: CPU write strobe (`RAM_enable_write`).
- `addr`, in, 16: word address on the bus, valid in the strobe cycle.
- `wdata`, in, 16: write data from MDR, valid with `wr_en`.
- `privileged`, in, 1: PSW privilege bit.
- `rdata`, out, 16: read data to MDR.
- `rdata_valid`, out, 1: one-cycle pulse when `rdata` updates.
- `fault`, out, 1: one-cycle pulse on any rejected access.
- `fault_code`, out, 2: cause of the last fault (0 none, 1 conflict, 2 range, 3 protect). Held until the next fault.
- `fault_count`, out, 8: saturating count of faults.
- `load_valid`, in, 1: loader has a word to write.
- `load_addr`, in, 16: loader address.
- `load_data`, in, 16: loader data.
- `load_ready`, out, 1: loader transfer accepted this cycle.

## Operation
- FSM states: IDLE and RD_RESP. IDLE goes to RD_RESP on an accepted read. RD_RESP returns to IDLE, or stays in RD_RESP if a new read is accepted in the same cycle.
- Read: `rd_en`=1, `wr_en`=0, and `addr` < 2^DEPTH_LOG2. The word is fetched and `rdata` is loaded; `rdata_valid` is high in RD_RESP. `rdata` holds its value until the next accepted read.
- Write: `wr_en`=1, `rd_en`=0, and `addr` in range. `wdata` is committed at the edge that ends the strobe cycle.
- Conflict: `rd_en` and `wr_en` both high. Neither access is performed; fault code 1.
- Range: address ≥ 2^DEPTH_LOG2. A read sets `rdata` to 0 and still pulses `rdata_valid`; a write is dropped. Fault code 2.
- Priority: the CPU has priority over the loader. `load_ready` = `load_valid` & ~`rd_en` & ~`wr_en`. A loader word is written when `load_ready` is high.
- Loader writes bypass protection. Out-of-range loader writes are dropped with fault code 2.
- `fault_count` increments on every fault pulse and saturates at 255.
- Read-after-write to the same address in consecutive cycles returns the new data.

## Timing
- Read latency: strobe in cycle N; `rdata`/`rdata_valid` valid in cycle N+1. This matches MDR_out in the following control state.
- Back-to-back reads every cycle are supported; `rdata_valid` stays high continuously.
- Write latency: data is visible to a read strobed in cycle N+1.
- `fault`, `fault_code`, and `fault_count` update at the edge ending the offending cycle, so they are visible in cycle N+1.
- Reset (asserted at any time, including during RD_RESP):
  - State returns to IDLE; any pending response is dropped.
  - `rdata`=0, `rdata_valid`=0, `fault`=0, `fault_code`=0, `fault_count`=0.
  - `load_ready` is 0 while reset is asserted.
  - RAM contents are not cleared.

## Configuration
- `MEM_WRITE_PROTECT_EN` defined: a CPU write with `addr` < `PROT_LIMIT` while `privileged`=0 is dropped and raises fault code 3. Privileged writes proceed normally.
- `MEM_WRITE_PROTECT_EN` undefined: `privileged` is ignored and fault code 3 is never produced. The port remains present.

## Structure
- Shared package `fpg8_mem_pkg` holds:
  - word width (16);
  - fault code constants FAULT_NONE, FAULT_CONFLICT, FAULT_RANGE, FAULT_PROT;
  - responder state encoding.
- One sub-module, `mem_array`: single-port synchronous RAM with one write and one registered read. It is parameterized by `DEPTH_LOG2`. `mem_responder` muxes CPU and loader traffic onto it.

## Test plan
- Loader writes 16'h1234 to address 5 while the CPU is idle. Then `rd_en` with `addr`=5 → `rdata`=16'h1234 with `rdata_valid` pulse in N+1.
- `wr_en` with `addr`=7, `wdata`=16'hBEEF in cycle N, then `rd_en` with `addr`=7 in N+1 → `rdata`=16'hBEEF in N+2.
- `rd_en`=`wr_en`=1 at `addr`=3 → memory unchanged, `fault` pulse, `fault_code`=1, `fault_count`=1.
- `rd_en` with `addr`=16'h0400 (DEPTH_LOG2=10) → `rdata`=0, `rdata_valid`=1, `fault_code`=2.
- With the macro defined: `wr_en` at `addr`=16'h0010 with `privileged`=0 → word unchanged, `fault_code`=3. Repeat with `privileged`=1 → write commits.
- `load_valid` held while the CPU issues `rd_en` → `load_ready`=0 during the strobe; the load completes the next cycle. Assert reset during RD_RESP → all outputs 0 immediately.

Source files
------------

// File: rtl/fpg8_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpg8_mem_pkg : shared word width, fault codes and responder state encoding
// rev 1.0
// ---------------------------------------------------------------------------
package fpg8_mem_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_CONFLICT = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;
  localparam logic [1:0] FAULT_PROT     = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_RESP = 1'b1
  } resp_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_array : single-port synchronous word RAM, one write or one registered read
// rev 1.0
// ---------------------------------------------------------------------------
module mem_array
  import fpg8_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // No reset on the array or its output register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_responder : FPG8 bus memory responder with loader port and fault reporting
// Optional CPU write protection below PROT_LIMIT: define MEM_WRITE_PROTECT_EN.
// rev 1.0
// ---------------------------------------------------------------------------
module mem_responder
  import fpg8_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] PROT_LIMIT = 16'h0040
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [15:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              privileged,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [7:0]        fault_count,
  input  logic              load_valid,
  input  logic [15:0]       load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  resp_state_e state_q, state_d;

  logic                  cpu_in_range, load_in_range;
  logic                  rd_acc, wr_req, cpu_strobe;
  logic                  prot_block;
  logic                  cpu_rd_ok, cpu_wr_ok, load_wr_ok;
  logic                  mem_en, mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata, mem_q;
  logic                  rdata_zero;
  logic                  fault_hit;
  logic [1:0]            fault_cause;

  assign cpu_in_range  = 32'(addr) < DEPTH;
  assign load_in_range = 32'(load_addr) < DEPTH;
  assign cpu_strobe    = rd_en | wr_en;
  assign rd_acc        = rd_en & ~wr_en;
  assign wr_req        = wr_en & ~rd_en;

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_block = wr_req & cpu_in_range & ~privileged & (addr < PROT_LIMIT);
`else
  logic unused_prot_cfg;
  assign unused_prot_cfg = ^{privileged, PROT_LIMIT};
  assign prot_block      = 1'b0;
`endif

  assign load_ready = load_valid & ~cpu_strobe & reset;

  assign cpu_rd_ok  = rd_acc & cpu_in_range;
  assign cpu_wr_ok  = wr_req & cpu_in_range & ~prot_block;
  assign load_wr_ok = load_ready & load_in_range;

  assign mem_en    = reset & (cpu_rd_ok | cpu_wr_ok | load_wr_ok);
  assign mem_we    = cpu_wr_ok | load_wr_ok;
  assign mem_addr  = cpu_strobe ? addr[DEPTH_LOG2-1:0] : load_addr[DEPTH_LOG2-1:0];
  assign mem_wdata = cpu_strobe ? wdata : load_data;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:    if (rd_acc) state_d = ST_RD_RESP;
      ST_RD_RESP: state_d = rd_acc ? ST_RD_RESP : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign rdata_valid = (state_q == ST_RD_RESP);

  // The RAM output register is not reset; this flag forces rdata to zero
  // after reset and for out-of-range reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rdata_zero <= 1'b1;
    else if (rd_acc) rdata_zero <= ~cpu_in_range;
  end

  assign rdata = rdata_zero ? '0 : mem_q;

  // Loader traffic only proceeds with no CPU strobe, so at most one cause per cycle.
  always_comb begin
    fault_hit   = 1'b0;
    fault_cause = FAULT_NONE;
    if (rd_en && wr_en) begin
      fault_hit   = 1'b1;
      fault_cause = FAULT_CONFLICT;
    end else if (cpu_strobe && !cpu_in_range) begin
      fault_hit   = 1'b1;
      fault_cause = FAULT_RANGE;
    end else if (prot_block) begin
      fault_hit   = 1'b1;
      fault_cause = FAULT_PROT;
    end else if (load_ready && !load_in_range) begin
      fault_hit   = 1'b1;
      fault_cause = FAULT_RANGE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault       <= 1'b0;
      fault_code  <= FAULT_NONE;
      fault_count <= 8'd0;
    end else begin
      fault <= fault_hit;
      if (fault_hit) begin
        fault_code  <= fault_cause;
        fault_count <= sat_inc8(fault_count);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_responder : directed self-checking bench for mem_responder
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0, privileged = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        rdata_valid, fault;
  logic [1:0]  fault_code;
  logic [7:0]  fault_count;
  logic        load_valid = 1'b0;
  logic [15:0] load_addr = '0, load_data = '0;
  logic        load_ready;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(
    .DEPTH_LOG2(10),
    .PROT_LIMIT(16'h0040)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .privileged (privileged),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_count(fault_count),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    load_valid = 1'b1;
    #1;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_count", fault_count, 0);
    load_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // loader write then CPU read
    load_valid = 1'b1; load_addr = 16'd5; load_data = 16'h1234;
    #1;
    chk("ld_ready_idle", load_ready, 1);
    step();
    load_valid = 1'b0;
    cpu_rd(16'd5);
    chk("rd5_data", rdata, 16'h1234);
    chk("rd5_valid", rdata_valid, 1);
    chk("rd5_fault", fault, 0);
    step();
    chk("valid_drop", rdata_valid, 0);

    // write then read-after-write
    wr_en = 1'b1; addr = 16'd7; wdata = 16'hBEEF;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    chk("wr_no_valid", rdata_valid, 0);
    step();
    rd_en = 1'b0;
    chk("raw7_data", rdata, 16'hBEEF);
    chk("raw7_valid", rdata_valid, 1);
    step();
    chk("rdata_hold", rdata, 16'hBEEF);
    chk("hold_valid", rdata_valid, 0);

    // conflicting strobes
    cpu_wr(16'd3, 16'h3333);
    rd_en = 1'b1; wr_en = 1'b1; addr = 16'd3; wdata = 16'hDEAD;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    chk("conf_count", fault_count, 1);
    chk("conf_valid", rdata_valid, 0);
    step();
    chk("conf_pulse_end", fault, 0);
    chk("conf_code_hold", fault_code, 1);
    cpu_rd(16'd3);
    chk("conf_mem_kept", rdata, 16'h3333);

    // out-of-range read
    cpu_rd(16'h0400);
    chk("rng_rd_data", rdata, 0);
    chk("rng_rd_valid", rdata_valid, 1);
    chk("rng_rd_fault", fault, 1);
    chk("rng_rd_code", fault_code, 2);
    chk("rng_rd_count", fault_count, 2);

    // back-to-back reads
    rd_en = 1'b1; addr = 16'd5;
    step();
    chk("b2b_1_data", rdata, 16'h1234);
    chk("b2b_1_valid", rdata_valid, 1);
    addr = 16'd7;
    step();
    rd_en = 1'b0;
    chk("b2b_2_data", rdata, 16'hBEEF);
    chk("b2b_2_valid", rdata_valid, 1);

    // out-of-range write must not alias onto address 5
    cpu_wr(16'h0405, 16'h0001);
    chk("rng_wr_fault", fault, 1);
    chk("rng_wr_count", fault_count, 3);
    cpu_rd(16'd5);
    chk("rng_wr_noalias", rdata, 16'h1234);

    // out-of-range loader write
    load_valid = 1'b1; load_addr = 16'h0805; load_data = 16'hFFFF;
    #1;
    chk("ld_rng_ready", load_ready, 1);
    step();
    load_valid = 1'b0;
    chk("ld_rng_fault", fault, 1);
    chk("ld_rng_code", fault_code, 2);
    chk("ld_rng_count", fault_count, 4);
    cpu_rd(16'd5);
    chk("ld_rng_noalias", rdata, 16'h1234);

    // protected region: loader bypasses, unprivileged CPU write depends on build
    load_valid = 1'b1; load_addr = 16'h0010; load_data = 16'hAAAA;
    step();
    load_valid = 1'b0;
    privileged = 1'b0;
    cpu_wr(16'h0010, 16'h5555);
`ifdef MEM_WRITE_PROTECT_EN
    chk("prot_fault", fault, 1);
    chk("prot_code", fault_code, 3);
    chk("prot_count", fault_count, 5);
    cpu_rd(16'h0010);
    chk("prot_kept", rdata, 16'hAAAA);
`else
    chk("noprot_fault", fault, 0);
    chk("noprot_count", fault_count, 4);
    cpu_rd(16'h0010);
    chk("noprot_commit", rdata, 16'h5555);
`endif
    privileged = 1'b1;
    cpu_wr(16'h0010, 16'h6666);
    privileged = 1'b0;
    chk("priv_fault", fault, 0);
    cpu_rd(16'h0010);
    chk("priv_commit", rdata, 16'h6666);

    // loader stalled by CPU read, then completes
    load_valid = 1'b1; load_addr = 16'd9; load_data = 16'h9999;
    rd_en = 1'b1; addr = 16'd5;
    #1;
    chk("ld_blocked", load_ready, 0);
    step();
    rd_en = 1'b0;
    #1;
    chk("ld_resume", load_ready, 1);
    chk("ld_blk_rdata", rdata, 16'h1234);
    step();
    load_valid = 1'b0;
    rd_en = 1'b1; addr = 16'd9;
    step();
    chk("ld9_data", rdata, 16'h9999);
    chk("ld9_valid", rdata_valid, 1);

    // asynchronous reset while in RD_RESP
    reset = 1'b0;
    load_valid = 1'b1;
    #1;
    chk("arst_rdata", rdata, 0);
    chk("arst_valid", rdata_valid, 0);
    chk("arst_fault", fault, 0);
    chk("arst_code", fault_code, 0);
    chk("arst_count", fault_count, 0);
    chk("arst_load_ready", load_ready, 0);
    load_valid = 1'b0; rd_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_valid", rdata_valid, 0);
    cpu_rd(16'd9);
    chk("ram_retained", rdata, 16'h9999);

    // fault counter saturation
    rd_en = 1'b1; wr_en = 1'b1; addr = 16'd3; wdata = 16'h0BAD;
    for (int i = 0; i < 260; i++) step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("sat_count", fault_count, 255);
    chk("sat_code", fault_code, 1);
    cpu_rd(16'd3);
    chk("sat_mem_kept", rdata, 16'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
